// File: rtl/shift_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_chain_pkg
// Description : State encoding and requester indices for the shared shift chain
// Revision    : 1.0 - initial release
// ============================================================================
package shift_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/shift_chain.sv
`default_nettype none
// ============================================================================
// Module      : shift_chain
// Description : DEPTH-stage serial data+valid delay line with async clear
// Revision    : 1.0 - initial release
// ============================================================================
module shift_chain #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic din_valid,
  output logic dout,
  output logic dout_valid
);

  logic [DEPTH-1:0] r_data;
  logic [DEPTH-1:0] r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_vld  <= '0;
    end else begin
      r_data[0] <= din;
      r_vld[0]  <= din_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
    end
  end

  assign dout       = r_data[DEPTH-1];
  assign dout_valid = r_vld[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/shift_chain_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_chain_arb_ctrl
// Description : Round-robin arbiter feeding one granted word LSB-first into a
//               shared serial chain, then draining it and pulsing done
// Revision    : 1.0 - initial release
// ============================================================================
module shift_chain_arb_ctrl
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             owner,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] c_BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] c_DRN_LAST = DW'((DEPTH > 1) ? (DEPTH - 2) : 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_word;
  logic [BW-1:0]    r_bcnt;
  logic [DW-1:0]    r_dcnt;
  logic             r_last;
  logic [1:0]       r_gnt;
  logic             r_owner;
  logic             r_busy;
  logic             r_done;
  logic             w_grant;
  logic             w_winner;
  logic             w_push;

  always_comb begin
    w_grant     = (r_state == IDLE) && (req != 2'b00);
    w_push      = (r_state == SHIFT);
    w_winner    = REQ0;
    w_state_nxt = r_state;
    case (req)
      2'b01:   w_winner = REQ0;
      2'b10:   w_winner = REQ1;
      2'b11:   w_winner = ~r_last;
      default: w_winner = REQ0;
    endcase
    case (r_state)
      IDLE:  if (w_grant) w_state_nxt = SHIFT;
      SHIFT: begin
        if (r_bcnt == c_BIT_LAST) begin
          // With a single stage the last bit is already at the output
          if (DEPTH == 1) w_state_nxt = IDLE;
          else            w_state_nxt = DRAIN;
        end
      end
      DRAIN: if (r_dcnt == c_DRN_LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_bcnt  <= '0;
      r_dcnt  <= '0;
      r_last  <= REQ1;
      r_gnt   <= 2'b00;
      r_owner <= REQ0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_gnt  <= 2'b00;
      r_busy <= (r_state != IDLE) || w_grant;
      r_done <= (r_state != IDLE) && (w_state_nxt == IDLE);
      if (w_grant) begin
        r_gnt   <= (w_winner == REQ1) ? 2'b10 : 2'b01;
        r_owner <= w_winner;
        r_last  <= w_winner;
        r_word  <= (w_winner == REQ1) ? data1 : data0;
        r_bcnt  <= '0;
      end
      if (w_push) begin
        r_word <= {1'b0, r_word[WIDTH-1:1]};
        r_bcnt <= r_bcnt + BW'(1);
        r_dcnt <= '0;
      end
      if (r_state == DRAIN) r_dcnt <= r_dcnt + DW'(1);
    end
  end

  shift_chain #(.DEPTH(DEPTH)) u_chain (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (r_word[0]),
    .din_valid  (w_push),
    .dout       (sout),
    .dout_valid (sout_valid)
  );

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_chain_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_chain_arb_ctrl
// Description : Scoreboard bench for shift_chain_arb_ctrl with a timeline model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_chain_arb_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req   = 2'b00;
  logic [WIDTH-1:0] data0 = '0;
  logic [WIDTH-1:0] data1 = '0;
  logic [1:0]       gnt;
  logic             owner;
  logic             busy;
  logic             sout;
  logic             sout_valid;
  logic             done;

  shift_chain_arb_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .gnt        (gnt),
    .owner      (owner),
    .busy       (busy),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [1:0] oh; } gexp_t;
  typedef struct { int cyc; logic b; logic last; } bexp_t;

  gexp_t gq[$];
  bexp_t bq[$];

  int         cyc       = 0;
  int         free_e    = 0;
  int         b_lo      = 1;
  int         b_hi      = 0;
  int         m_gnt_cyc = -1;
  logic [1:0] m_gnt_oh  = 2'b00;
  logic       m_owner   = 1'b0;
  int         m_pref    = 0;
  int         m_w;
  logic [1:0] m_oh;
  logic [WIDTH-1:0] m_word;

  int vectors     = 0;
  int miscompares = 0;

  // Transaction timeline: a grant at edge g fixes every later observable event
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gq.delete();
      bq.delete();
      free_e    = 0;
      b_lo      = 1;
      b_hi      = 0;
      m_owner   = 1'b0;
      m_pref    = 0;
      m_gnt_cyc = -1;
      m_gnt_oh  = 2'b00;
    end else begin
      cyc++;
      if (cyc >= free_e && req != 2'b00) begin
        if (req == 2'b11) m_w = m_pref;
        else              m_w = req[1] ? 1 : 0;
        m_pref = 1 - m_w;
        m_word = (m_w == 1) ? data1 : data0;
        m_oh   = (m_w == 1) ? 2'b10 : 2'b01;
        gq.push_back('{cyc, m_oh});
        for (int i = 0; i < WIDTH; i++)
          bq.push_back('{cyc + DEPTH + i, m_word[i], (i == WIDTH - 1)});
        free_e    = cyc + DEPTH + WIDTH;
        b_lo      = cyc;
        b_hi      = cyc + DEPTH + WIDTH - 1;
        m_owner   = (m_w == 1);
        m_gnt_cyc = cyc;
        m_gnt_oh  = m_oh;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  logic [1:0] e_gnt;
  logic       e_v, e_b, e_last;

  initial begin : monitor
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        chk("rst_gnt",   32'(gnt),        32'd0);
        chk("rst_owner", 32'(owner),      32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_sout",  32'(sout),       32'd0);
        chk("rst_valid", 32'(sout_valid), 32'd0);
        chk("rst_done",  32'(done),       32'd0);
      end else begin
        e_gnt = 2'b00;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
          e_gnt = gq[0].oh;
          void'(gq.pop_front());
        end
        e_v = 1'b0; e_b = 1'b0; e_last = 1'b0;
        if (bq.size() > 0 && bq[0].cyc == cyc) begin
          e_v = 1'b1; e_b = bq[0].b; e_last = bq[0].last;
          void'(bq.pop_front());
        end
        chk("gnt",        32'(gnt),        32'(e_gnt));
        chk("owner",      32'(owner),      32'(m_owner));
        chk("busy",       32'(busy),       32'((cyc >= b_lo) && (cyc <= b_hi)));
        chk("sout_valid", 32'(sout_valid), 32'(e_v));
        chk("done",       32'(done),       32'(e_last));
        if (e_v) chk("sout", 32'(sout), 32'(e_b));
      end
    end
  end

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    if (i == 0) data0 = v;
    else        data1 = v;
  endtask

  task automatic wait_gnt(input int i);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_gnt_cyc == cyc && m_gnt_oh[i]) return;
    end
  endtask

  task automatic wait_any();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_gnt_cyc == cyc && m_gnt_oh != 2'b00) return;
    end
  endtask

  logic granted;

  initial begin : stim
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Contention straight out of reset: 4 alternating grants
    data0 = 8'h0F; data1 = 8'hF0; req = 2'b11;
    for (int k = 0; k < 4; k++) wait_any();
    req = 2'b00;
    repeat (14) @(negedge clk);

    // Single request
    data0 = 8'hA5; req = 2'b01;
    wait_gnt(0);
    req = 2'b00; data0 = 8'h00;
    repeat (14) @(negedge clk);

    // Late request from requester 1 while requester 0 shifts
    data0 = 8'h3C; req = 2'b01;
    wait_gnt(0);
    req = 2'b00;
    repeat (3) @(negedge clk);
    data1 = 8'h5A; req = 2'b10;
    repeat (2) @(negedge clk);
    data1 = 8'hC3;
    wait_gnt(1);
    data1 = 8'h00; req = 2'b00;
    repeat (14) @(negedge clk);

    // Idle
    repeat (20) @(negedge clk);

    // Randomised traffic; each requester holds until granted
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        granted = (m_gnt_cyc == cyc) && m_gnt_oh[i];
        if (granted) begin
          set_data(i, WIDTH'($urandom));
          req[i] = ($urandom_range(0, 2) == 0);
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            set_data(i, WIDTH'($urandom));
          end
        end else if ($urandom_range(0, 7) == 0) begin
          set_data(i, WIDTH'($urandom));
        end
      end
    end
    req = 2'b00;
    repeat (20) @(negedge clk);

    // Reset in cycle 6 of an all-ones transfer
    data0 = 8'hFF; req = 2'b01;
    wait_gnt(0);
    req = 2'b00;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Pointer must be back at requester 0 after reset
    data0 = 8'h12; data1 = 8'h34; req = 2'b11;
    wait_gnt(0);
    req[0] = 1'b0;
    wait_gnt(1);
    req = 2'b00;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_chain_arb_ctrl.md
Name: shift_chain_arb_ctrl

Overview:
- Shares one DEPTH-stage serial shift chain between two requesters.
- Arbitrates round-robin, loads the granted WIDTH-bit word and shifts it LSB-first into the chain, then drains it.
- Reports completion with a `done` pulse.
- Sits between parallel producers and a single serial delay-line consumer.

Parameters:
- WIDTH, 8, bits per transfer word (>=2).
- DEPTH, 4, number of register stages in the serial chain (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  request per requester; held with data until granted.
- data0  in  WIDTH  word from requester 0.
- data1  in  WIDTH  word from requester 1.
- gnt  out  2  one-hot, one-cycle acceptance pulse (registered).
- owner  out  1  index of requester whose word is in flight.
- busy  out  1  high from grant cycle through done cycle inclusive.
- sout  out  1  serial output = last chain stage.
- sout_valid  out  1  `sout` carries a valid bit.
- done  out  1  one-cycle pulse coincident with the last valid `sout` bit.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; shift word, counters and all chain stages and valid bits cleared; round-robin pointer prefers requester 0.
- Clock and reset: one clock, clk; reset asynchronous active-low, rst_n.
- Cycle numbering: cycle k is the interval after rising edge k; the grant edge is edge 0.
- States: IDLE, SHIFT, DRAIN.
- IDLE, no request: `req`==0 -> stay; chain input valid = 0.
- IDLE, request present: on the edge where `req`!=0:
  - pick the winner;
  - load the shift word from the winner's data;
  - gnt <= onehot(winner), owner <= winner, busy <= 1, bit counter <= 0;
  - go to SHIFT.
- Arbitration: single requester wins directly. Both requesting -> the one not granted last wins; after reset requester 0 wins. Pointer updates only on a grant.
- SHIFT: each edge pushes shift-word bit 0 with valid=1 into chain stage 0, shifts the word right, and increments the counter. After WIDTH pushes -> DRAIN.
- DRAIN: chain input valid = 0. Count DEPTH-1 edges, then -> IDLE.
- The state is IDLE in the cycle `done` is high.
- Chain: DEPTH stages of data and valid bits, all updated in parallel each edge (true shift register; no stage is skipped). `sout`/`sout_valid` come from stage DEPTH-1.
- Latency:
  - gnt high in cycle 0 only;
  - sout_valid high for cycles DEPTH..DEPTH+WIDTH-1, contiguous;
  - done and busy-fall: done high in cycle DEPTH+WIDTH-1; busy low from cycle DEPTH+WIDTH.
  - Next gnt is possible in cycle DEPTH+WIDTH at the earliest.
- Handshake rules:
  - `req` is ignored outside IDLE.
  - A requester still holding `req` after its grant is treated as a new request at the next IDLE.
  - The data input is sampled only at the grant edge.
- Reset mid-transfer: immediate abort. Chain flushed, no `done` pulse, no partial bits after release. First grant after release follows the reset pointer.
- Simultaneous events: `done` cycle plus pending `req` -> grant at the following edge (no overlap).
- Counter widths: $clog2(WIDTH+1) for the bit counter, $clog2(DEPTH+1) for the drain counter. No wrap-around inside a transfer.

Decomposition:
- Package shift_chain_pkg: state encoding constants IDLE/SHIFT/DRAIN, and requester index constants REQ0/REQ1.
- Sub-module shift_chain: parameter DEPTH; ports clk, rst_n, din, din_valid, dout, dout_valid; DEPTH-stage data+valid chain with async clear.
- The controller instantiates one shift_chain.

Test Plan (WIDTH=8, DEPTH=4):
- Single request: req=2'b01, data0=8'hA5 -> gnt=01 in cycle 0; sout_valid cycles 4..11 with sout=1,0,1,0,0,1,0,1; done in cycle 11 only; busy cycles 0..11; owner=0.
- Contention after reset: req=2'b11, data0=8'h0F, data1=8'hF0 held -> first gnt=01 streams 1,1,1,1,0,0,0,0; next gnt=10 in cycle 12 streams 0,0,0,0,1,1,1,1; done pulses in cycles 11 and 23.
- Fairness: both req held for 4 transfers -> gnt sequence 01,10,01,10 at cycles 0,12,24,36; no gap in arbitration beyond the required one cycle.
- Late request: req1 asserted during SHIFT of requester 0 -> no gnt until cycle 12; then gnt=10; data1 change before the grant is reflected, change after the grant is ignored.
- Reset mid-transfer: rst_n=0 in cycle 6 of a 8'hFF transfer -> sout, sout_valid, busy, done all 0 at once; after release with req idle, sout_valid stays 0 and no done.
- Idle behaviour: req=0 for 20 cycles -> gnt, busy, sout_valid, done all remain 0.
